imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter that shares the single registered read port of the instruction memory between a fetch requester (port 0, CPU fetch stage) and an auxiliary requester (port 1, debug/loader read-back). It grants at most one read per cycle, drives the memory address, and routes the returned big-endian instruction word to the owner one cycle later. It also rejects misaligned addresses with an error response. It sits between the fetch stage / debug unit and `instmem`.

## Interface
- `WORD_WIDTH`, 32, instruction and address width
- `clk`  in  1  system clock; instruction memory samples on the same rising edge
- `nrst`  in  1  asynchronous active-low reset
- `p0_req`, `p1_req`  in  1  read request; held until granted
- `p0_addr`, `p1_addr`  in  WORD_WIDTH  byte address; held with req
- `p0_gnt`, `p1_gnt`  out  1  combinational grant this cycle
- `p0_rvalid`, `p1_rvalid`  out  1  response valid, one cycle after grant
- `p0_rdata`, `p1_rdata`  out  WORD_WIDTH  instruction word during rvalid, else 0
- `p0_err`, `p1_err`  out  1  misaligned-address error, qualified by rvalid
- `mem_addr`  out  WORD_WIDTH  address to instruction memory
- `mem_inst`  in  WORD_WIDTH  instruction memory read data

## Operation
- Grant:
  - At most one of `p0_gnt`/`p1_gnt` is high per cycle, and only when the matching req is high.
  - A single requester is always granted.
  - Contention is resolved by a priority pointer `prio` (0 or 1): the port named by `prio` wins.
- Pointer update: on every granted cycle, `prio` moves to the non-granted port (round-robin, see Configuration).
- Address:
  - `mem_addr` equals the granted port's address in the grant cycle.
  - With no grant, `mem_addr` holds the last granted address (register `addr_q`), so idle cycles do not toggle the memory.
- In-flight register, captured at the grant edge: `vld_q`, `own_q`, `err_q`.
  - `err_q` = granted `addr[1:0] != 2'b00`.
- Response:
  - In the cycle after the grant, the `rvalid` of port `own_q` is high for exactly one cycle.
  - `rdata` = `mem_inst` when `err_q` = 0. `rdata` = 0 and `err` = 1 when `err_q` = 1.
  - The non-owner port sees `rvalid` = 0 and `rdata` = 0.
- Back-to-back: a new grant may occur in the same cycle a response is delivered. Sustained throughput is one read per cycle.
- No backpressure on responses: requesters must accept `rvalid` unconditionally.

## Timing
- Latency: grant in cycle N; response in cycle N+1. This matches the memory's one-edge registered read.
- `mem_inst` carries the memory's output delay; `rdata` is a combinational pass-through and is valid at end of cycle N+1.
- Reset values:
  - `prio` = 0, `vld_q` = 0, `own_q` = 0, `err_q` = 0, `addr_q` = 0.
  - All `gnt`, `rvalid`, `err` = 0; all `rdata` = 0; `mem_addr` = 0.
  - Grants are forced low while `nrst` = 0.
- Reset mid-operation: an in-flight read is dropped, and no `rvalid` follows reset release.
  - The first grant after release goes to port 0 if both ports request.
- Simultaneous request, same address: only one port is granted. The loser keeps requesting and is served next cycle.
- Address wrap: `mem_addr` is passed unmodified; range checking belongs to the memory.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin arbitration as above. Under continuous dual requests, grants alternate p0, p1, p0, …
- Undefined: fixed priority, port 0 always wins. `prio` is constant 0 and port 1 is served only in cycles where `p0_req` = 0.

## Structure
- Shared package/header (`defines.h`) holds:
  - `WORD_WIDTH`
  - port-index constants `ARB_P0` = 0 and `ARB_P1` = 1
  - `ALIGN_MASK` = 2'b11
- One natural sub-module: `rr_arb2`, a two-input grant logic block with priority pointer. It is combinational grant plus the registered pointer, and it contains the `IMEM_ARB_RR_EN` switch.
- The remaining datapath (address mux, in-flight register, response routing) lives in `imem_arbiter`.

## Test plan
- Reset, then p0 requests 0x00000004 alone:
  - `p0_gnt` = 1 in the same cycle, `mem_addr` = 0x00000004.
  - Next cycle `p0_rvalid` = 1, `p0_rdata` = memory bytes 4..7 big-endian, `p0_err` = 0.
- p0 and p1 request continuously (0x10, 0x20):
  - With RR: grants p0, p1, p0, p1; responses follow each by one cycle with the matching word.
  - Without RR: p0 granted every cycle and p1 never granted.
- p1 requests 0x00000006:
  - Grant, then next cycle `p1_rvalid` = 1, `p1_err` = 1, `p1_rdata` = 0.
- p0 streams 0x0, 0x4, 0x8 on consecutive cycles:
  - Three consecutive `p0_rvalid` cycles, each carrying the word at the previous cycle's address.
- Assert `nrst` low in the cycle after a p0 grant, then release:
  - No `p0_rvalid` appears; all outputs are 0 during reset.
  - On the first contended cycle after release, port 0 wins.
- After a grant at 0x20, hold all reqs low for 3 cycles:
  - `mem_addr` stays 0x20, and no `rvalid` asserts.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory read arbiter.
package imem_arbiter_pkg;

  // Instruction and byte-address width.
  localparam int WORD_WIDTH = 32;

  // Number of requesting ports.
  localparam int NUM_PORTS = 2;

  // Port indices (also the encoding of the priority pointer and of the owner).
  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  // Any set bit under this mask marks a misaligned instruction address.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Read issued to memory last cycle, waiting for its data.
  typedef struct packed {
    logic vld;  // a read was granted at the last edge
    logic own;  // port that owns the response
    logic err;  // address was misaligned; suppress data
  } inflight_t;

  // Response presented to one port.
  typedef struct packed {
    logic                  rvalid;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  // True when the low address bits are not word aligned.
  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/imem_arbiter_arb.sv
// rr_arb2: two-input grant logic with a registered priority pointer.
// Build option: IMEM_ARB_RR_EN selects round-robin; otherwise port 0
// always wins and the pointer stays at 0.
module rr_arb2
  import imem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  logic prio;

  // Combinational grant: lone requester wins, contention goes to prio.
  // Grants are held low throughout reset.
  always_comb begin
    gnt = '0;
    if (nrst) begin
      if (req[0] && req[1]) begin
        if (prio == ARB_P1) gnt[1] = 1'b1;
        else                gnt[0] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Round-robin: after any grant, favour the port that was not granted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     prio <= ARB_P0;
    else if (|gnt) prio <= gnt[0] ? ARB_P1 : ARB_P0;
  end
`else
  // Fixed priority: pointer is pinned to port 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prio <= ARB_P0;
    else       prio <= ARB_P0;
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the registered instruction-memory read port between
// fetch (port 0) and debug/loader (port 1). One grant per cycle, response
// routed to the owner one cycle later, misaligned reads answered with err.
// Build option: IMEM_ARB_RR_EN (round-robin; default is fixed priority).
module imem_arbiter
  import imem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  p0_req,
  input  logic [WORD_WIDTH-1:0] p0_addr,
  input  logic                  p1_req,
  input  logic [WORD_WIDTH-1:0] p1_addr,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [WORD_WIDTH-1:0] p0_rdata,
  output logic [WORD_WIDTH-1:0] p1_rdata,
  output logic                  p0_err,
  output logic                  p1_err,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_inst
);

  logic [NUM_PORTS-1:0]                 req;
  logic [NUM_PORTS-1:0]                 gnt;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0]                addr_q;
  inflight_t                            fl_q;
  rsp_t      [NUM_PORTS-1:0]            rsp;

  assign req  = {p1_req, p0_req};
  assign addr = {p1_addr, p0_addr};

  rr_arb2 u_arb (
    .clk  (clk),
    .nrst (nrst),
    .req  (req),
    .gnt  (gnt)
  );

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  // Address mux: granted port's address, else hold the last one so the
  // memory address bus stays quiet on idle cycles.
  always_comb begin
    mem_addr = addr_q;
    if (gnt[0])      mem_addr = addr[0];
    else if (gnt[1]) mem_addr = addr[1];
  end

  // In-flight register: remember who owns next cycle's memory data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fl_q   <= '0;
      addr_q <= '0;
    end else begin
      fl_q.vld <= |gnt;
      if (|gnt) begin
        fl_q.own <= gnt[1];
        fl_q.err <= misaligned(mem_addr[1:0]);
        addr_q   <= mem_addr;
      end
    end
  end

  // Response routing: only the owner sees rvalid; data is zero unless
  // valid and aligned.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    always_comb begin
      rsp[p]        = '0;
      rsp[p].rvalid = fl_q.vld && (fl_q.own == p[0]);
      rsp[p].err    = rsp[p].rvalid && fl_q.err;
      if (rsp[p].rvalid && !fl_q.err) rsp[p].rdata = mem_inst;
    end
  end

  assign p0_rvalid = rsp[0].rvalid;
  assign p0_rdata  = rsp[0].rdata;
  assign p0_err    = rsp[0].err;
  assign p1_rvalid = rsp[1].rvalid;
  assign p1_rdata  = rsp[1].rdata;
  assign p1_err    = rsp[1].err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter. Memory byte at address a holds a[7:0],
// so the big-endian word at 0x10 is 0x10111213.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        p0_req, p1_req;
  logic [31:0] p0_addr, p1_addr;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_inst;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  imem_arbiter dut (
    .clk       (clk),
    .nrst      (nrst),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p1_req    (p1_req),
    .p1_addr   (p1_addr),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .p0_err    (p0_err),
    .p1_err    (p1_err),
    .mem_addr  (mem_addr),
    .mem_inst  (mem_inst)
  );

  always #5 clk = ~clk;

  // Registered-read memory model: byte value equals its low address byte.
  always @(posedge clk) begin
    logic [7:0] b;
    b = mem_addr[7:0];
    mem_inst <= {b, b + 8'd1, b + 8'd2, b + 8'd3};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per delivered response.
  always @(negedge clk) begin
    if (p0_rvalid || p1_rvalid) begin
      if (p0_rvalid && p1_rvalid) begin
        chk("both_rvalid", {p1_rvalid, p0_rvalid}, 32'h1);
      end else if (q.size() == 0) begin
        chk("unexpected_rvalid", {p1_rvalid, p0_rvalid}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_port",  {31'd0, p1_rvalid}, {31'd0, e.port});
        chk("rsp_data",  p1_rvalid ? p1_rdata : p0_rdata, e.data);
        chk("rsp_err",   {31'd0, p1_rvalid ? p1_err : p0_err}, {31'd0, e.err});
        chk("rsp_other", p1_rvalid ? p0_rdata : p1_rdata, 32'h0);
      end
    end
  end

  // Drive one cycle, check grant/address, queue the expected response.
  task automatic step(input string name,
                      input logic r0, input logic [31:0] a0,
                      input logic r1, input logic [31:0] a1,
                      input logic eg0, input logic eg1, input logic [31:0] emaddr,
                      input logic [31:0] edata, input logic eerr);
    exp_t e;
    p0_req = r0; p0_addr = a0; p1_req = r1; p1_addr = a1;
    @(negedge clk);
    chk({name, "/p0_gnt"}, {31'd0, p0_gnt}, {31'd0, eg0});
    chk({name, "/p1_gnt"}, {31'd0, p1_gnt}, {31'd0, eg1});
    chk({name, "/mem_addr"}, mem_addr, emaddr);
    if (eg0 || eg1) begin
      e.port = eg1; e.data = edata; e.err = eerr;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "/gnt"},    {30'd0, p1_gnt, p0_gnt}, 32'h0);
    chk({name, "/rvalid"}, {30'd0, p1_rvalid, p0_rvalid}, 32'h0);
    chk({name, "/err"},    {30'd0, p1_err, p0_err}, 32'h0);
    chk({name, "/p0_rdata"}, p0_rdata, 32'h0);
    chk({name, "/p1_rdata"}, p1_rdata, 32'h0);
    chk({name, "/mem_addr"}, mem_addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rr;
`ifdef IMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    // Reset with both ports requesting: grants must stay low.
    nrst = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h40; p1_req = 1'b1; p1_addr = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    nrst = 1'b1; p0_req = 1'b0; p1_req = 1'b0;

    // Single p0 read.
    step("single", 1, 32'h4, 0, 32'h0, 1, 0, 32'h4, 32'h04050607, 0);
    // Misaligned p1 read (leaves RR pointer at port 0).
    step("misalign", 0, 32'h0, 1, 32'h6, 0, 1, 32'h6, 32'h0, 1);

    // Continuous contention.
    for (int i = 0; i < 4; i++) begin
      logic w1;
      w1 = rr && i[0];
      step("contend", 1, 32'h10, 1, 32'h20, !w1, w1,
           w1 ? 32'h20 : 32'h10, w1 ? 32'h20212223 : 32'h10111213, 0);
    end

    // Back-to-back stream on p0.
    step("stream0", 1, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h00010203, 0);
    step("stream1", 1, 32'h4, 0, 32'h0, 1, 0, 32'h4, 32'h04050607, 0);
    step("stream2", 1, 32'h8, 0, 32'h0, 1, 0, 32'h8, 32'h08090a0b, 0);

    // Grant p0, then reset before its response: the read is dropped.
    p0_req = 1'b1; p0_addr = 32'h30; p1_req = 1'b0;
    @(negedge clk);
    chk("pre_rst/p0_gnt", {31'd0, p0_gnt}, 32'h1);
    @(posedge clk); #1;
    nrst = 1'b0; p1_req = 1'b1; p1_addr = 32'h20;
    @(negedge clk);
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    nrst = 1'b1;
    step("post_rst", 1, 32'h30, 1, 32'h20, 1, 0, 32'h30, 32'h30313233, 0);

    // Idle hold of the last address.
    step("idle_set", 0, 32'h0, 1, 32'h20, 0, 1, 32'h20, 32'h20212223, 0);
    for (int i = 0; i < 3; i++)
      step("idle", 0, 32'h0, 0, 32'h0, 0, 0, 32'h20, 32'h0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
